// File: rtl/alu_issue.sv
// ID/EX issue stage: decodes a MIPS instruction into ALU control fields and
// registers them in an ID/EX pipeline register with stall (hold) and flush (bubble).
module alu_issue #(
   parameter int unsigned LUI_SHIFT = 16,
   parameter int unsigned LINK_REG  = 31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [31:0] id_instr,
   input  logic        stall,
   input  logic        flush,
   output logic        ex_valid,
   output logic [5:0]  ex_ALUFun,
   output logic        ex_Sign,
   output logic        ex_ALUSrc1,
   output logic        ex_ALUSrc2,
   output logic [31:0] ex_imm32,
   output logic [4:0]  ex_shamt,
   output logic [4:0]  ex_wr_reg,
   output logic        ex_reg_write,
   output logic        ex_illegal
);

   localparam logic [5:0] ALU_ADD = 6'b000000;
   localparam logic [5:0] ALU_SUB = 6'b000001;
   localparam logic [5:0] ALU_AND = 6'b011000;
   localparam logic [5:0] ALU_OR  = 6'b011110;
   localparam logic [5:0] ALU_XOR = 6'b010110;
   localparam logic [5:0] ALU_NOR = 6'b010001;
   localparam logic [5:0] ALU_SLL = 6'b100000;
   localparam logic [5:0] ALU_SRL = 6'b100001;
   localparam logic [5:0] ALU_SRA = 6'b100011;
   localparam logic [5:0] ALU_EQ  = 6'b110011;
   localparam logic [5:0] ALU_NEQ = 6'b110001;
   localparam logic [5:0] ALU_LT  = 6'b110101;
   localparam logic [5:0] ALU_LEZ = 6'b111101;
   localparam logic [5:0] ALU_GTZ = 6'b111111;
   localparam logic [5:0] ALU_LTZ = 6'b111010;

   localparam logic [5:0] OP_R      = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef struct packed {
      logic        valid;
      logic [5:0]  alu_fun;
      logic        sign;
      logic        alu_src1;
      logic        alu_src2;
      logic [31:0] imm32;
      logic [4:0]  shamt;
      logic [4:0]  wr_reg;
      logic        reg_write;
      logic        illegal;
   } issue_t;

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [31:0] imm_sx;
   logic [31:0] imm_zx;

   assign op     = id_instr[31:26];
   assign funct  = id_instr[5:0];
   assign rt     = id_instr[20:16];
   assign rd     = id_instr[15:11];
   assign imm_sx = {{16{id_instr[15]}}, id_instr[15:0]};
   assign imm_zx = {16'h0000, id_instr[15:0]};

   issue_t dec;
   issue_t q;

   always_comb begin
      dec           = '0;
      dec.valid     = 1'b1;
      dec.alu_fun   = ALU_ADD;
      dec.shamt     = id_instr[10:6];
      case (op)
         OP_R: begin
            dec.wr_reg    = rd;
            dec.reg_write = 1'b1;
            case (funct)
               FN_ADD:  dec.sign = 1'b1;
               FN_ADDU: ;
               FN_SUB:  begin dec.alu_fun = ALU_SUB; dec.sign = 1'b1; end
               FN_SUBU: dec.alu_fun = ALU_SUB;
               FN_AND:  dec.alu_fun = ALU_AND;
               FN_OR:   dec.alu_fun = ALU_OR;
               FN_XOR:  dec.alu_fun = ALU_XOR;
               FN_NOR:  dec.alu_fun = ALU_NOR;
               FN_SLT:  begin dec.alu_fun = ALU_LT; dec.sign = 1'b1; end
               FN_SLTU: dec.alu_fun = ALU_LT;
               FN_SLL:  begin dec.alu_fun = ALU_SLL; dec.alu_src1 = 1'b1; end
               FN_SRL:  begin dec.alu_fun = ALU_SRL; dec.alu_src1 = 1'b1; end
               FN_SRA:  begin dec.alu_fun = ALU_SRA; dec.alu_src1 = 1'b1; end
               FN_JR:   dec.reg_write = 1'b0;
               default: dec.illegal = 1'b1;
            endcase
         end
         OP_J: ;
         OP_JAL: begin
            dec.wr_reg    = 5'(LINK_REG);
            dec.reg_write = 1'b1;
         end
         default: begin
            // I-type common fields; branches override the operand select and write.
            dec.alu_src2  = 1'b1;
            dec.imm32     = imm_sx;
            dec.wr_reg    = rt;
            dec.reg_write = 1'b1;
            case (op)
               OP_ADDI:  dec.sign = 1'b1;
               OP_ADDIU: ;
               OP_SLTI:  begin dec.alu_fun = ALU_LT; dec.sign = 1'b1; end
               OP_SLTIU: dec.alu_fun = ALU_LT;
               OP_ANDI:  begin dec.alu_fun = ALU_AND; dec.imm32 = imm_zx; end
               OP_ORI:   begin dec.alu_fun = ALU_OR;  dec.imm32 = imm_zx; end
               OP_LUI: begin
                  dec.alu_fun  = ALU_SLL;
                  dec.alu_src1 = 1'b1;
                  dec.shamt    = 5'(LUI_SHIFT);
                  dec.imm32    = imm_zx;
               end
               OP_LW:    ;
               OP_SW:    dec.reg_write = 1'b0;
               OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
                  dec.alu_src2  = 1'b0;
                  dec.reg_write = 1'b0;
                  dec.sign      = 1'b1;
                  case (op)
                     OP_BEQ:  dec.alu_fun = ALU_EQ;
                     OP_BNE:  dec.alu_fun = ALU_NEQ;
                     OP_BLEZ: dec.alu_fun = ALU_LEZ;
                     OP_BGTZ: dec.alu_fun = ALU_GTZ;
                     default: begin
                        dec.alu_fun = ALU_LTZ;
                        if (rt != 5'd0) dec.illegal = 1'b1;
                     end
                  endcase
               end
               default: dec.illegal = 1'b1;
            endcase
         end
      endcase

      // Illegal encodings issue as a harmless ADD that writes nothing.
      if (dec.illegal) begin
         dec         = '0;
         dec.valid   = 1'b1;
         dec.illegal = 1'b1;
      end
      if (dec.wr_reg == 5'd0) dec.reg_write = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (flush) begin
         q <= '0;
      end else if (!stall) begin
         q <= id_valid ? dec : '0;
      end
   end

   assign ex_valid     = q.valid;
   assign ex_ALUFun    = q.alu_fun;
   assign ex_Sign      = q.sign;
   assign ex_ALUSrc1   = q.alu_src1;
   assign ex_ALUSrc2   = q.alu_src2;
   assign ex_imm32     = q.imm32;
   assign ex_shamt     = q.shamt;
   assign ex_wr_reg    = q.wr_reg;
   assign ex_reg_write = q.reg_write;
   assign ex_illegal   = q.illegal;

endmodule
